// File: rtl/lrelu_pkg.sv
// Shared definitions for the leaky-ReLU engine front end: tuser bit map,
// configuration-beat counts and the sequencer state encoding.
package lrelu_pkg;

    localparam int I_IS_NOT_MAX      = 0;
    localparam int I_IS_MAX          = 1;
    localparam int I_IS_LRELU        = 2;
    localparam int I_IS_TOP_BLOCK    = 3;
    localparam int I_IS_BOTTOM_BLOCK = 4;
    localparam int I_IS_1X1          = 5;
    localparam int I_IS_LEFT_COL     = 6;
    localparam int I_IS_RIGHT_COL    = 7;

    // Parameter words the engine consumes before data, minus 2.
    localparam int DEF_CONFIG_BEATS_3X3_2 = 19;
    localparam int DEF_CONFIG_BEATS_1X1_2 = 11;

    typedef enum logic [1:0] {
        IDLE,
        CONFIG,
        DATA
    } state_t;

endpackage

// File: rtl/axis_reg_slice.sv
// One-stage AXI-Stream forward register slice; out_* are driven only by flops
// and hold steady while out_valid && !out_ready.
module axis_reg_slice #(
    parameter int WIDTH = 8
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    // NOTE: non-blocking assignments so every flop samples pre-edge values and
    // simulation matches the synthesized registers regardless of block order.
    always_ff @(posedge aclk) begin
        if (areset) begin
            out_valid <= 1'b0;
            // NOTE: the data register is reset too, because its reset value is
            // visible on the port; a pure pipeline register would not need it.
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/axis_lrelu_tuser_sequencer.sv
// Frames raw accumulator beats for axis_lrelu_engine: counts config beats,
// then data beats, and generates tuser flags and tlast behind a register slice.
module axis_lrelu_tuser_sequencer
    import lrelu_pkg::*;
#(
    parameter int TDATA_WIDTH          = 384,
    parameter int COLS_W               = 8,
    parameter int BLOCKS_W             = 8,
    parameter int CONFIG_BEATS_3X3_2   = DEF_CONFIG_BEATS_3X3_2,
    parameter int CONFIG_BEATS_1X1_2   = DEF_CONFIG_BEATS_1X1_2,
    parameter int TUSER_WIDTH_LRELU_IN = 8
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic                            cfg_valid,
    output logic                            cfg_ready,
    input  logic                            cfg_is_1x1,
    input  logic                            cfg_is_lrelu,
    input  logic                            cfg_is_max,
    input  logic [COLS_W-1:0]               cfg_cols,
    input  logic [BLOCKS_W-1:0]             cfg_blocks,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic [TDATA_WIDTH-1:0]          s_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [TDATA_WIDTH-1:0]          m_axis_tdata,
    output logic                            m_axis_tlast,
    output logic [TUSER_WIDTH_LRELU_IN-1:0] m_axis_tuser,
    output logic                            frame_done
);

    localparam int CNT_W   = COLS_W + 2;  // holds 3*cols-1
    localparam int CFG_W   = 16;
    localparam int SLICE_W = 1 + TUSER_WIDTH_LRELU_IN + TDATA_WIDTH;

    state_t                state;
    logic                  is_1x1, is_lrelu, is_max;
    logic [CFG_W-1:0]      cfg_cnt, cfg_last;
    logic [CNT_W-1:0]      col_cnt, col_last, right_last;
    logic [BLOCKS_W-1:0]   blk_cnt, blk_last;

    logic [COLS_W-1:0]     cols_in;
    logic [BLOCKS_W-1:0]   blocks_in;
    logic                  s_hs, slice_ready, last_beat, top_block;
    logic [TUSER_WIDTH_LRELU_IN-1:0] tuser;
    logic [SLICE_W-1:0]    slice_out;

    assign cols_in   = (cfg_cols == '0) ? COLS_W'(1) : cfg_cols;
    assign blocks_in = (cfg_blocks == '0) ? BLOCKS_W'(1) : cfg_blocks;

    assign cfg_ready     = (state == IDLE);
    assign s_axis_tready = (state != IDLE) && slice_ready;
    assign s_hs          = s_axis_tvalid && s_axis_tready;

    assign top_block = (blk_cnt == '0);
    assign last_beat = (state == DATA) && (col_cnt == col_last) && (blk_cnt == blk_last);

    // NOTE: every output of this block gets a default first, so no path
    // leaves a bit unassigned and no latch is inferred.
    always_comb begin
        tuser = '0;
        tuser[I_IS_NOT_MAX] = !is_max;
        tuser[I_IS_MAX]     = is_max;
        tuser[I_IS_LRELU]   = is_lrelu;
        tuser[I_IS_1X1]     = is_1x1;
        if (state == DATA) begin
            tuser[I_IS_LEFT_COL]     = (col_cnt == '0);
            // Right edge stays at cols-1 even when a 1x1 row is 3*cols beats.
            tuser[I_IS_RIGHT_COL]    = (col_cnt == right_last);
            tuser[I_IS_TOP_BLOCK]    = top_block;
            tuser[I_IS_BOTTOM_BLOCK] = (blk_cnt == blk_last) && !top_block;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= IDLE;
            is_1x1     <= 1'b0;
            is_lrelu   <= 1'b0;
            is_max     <= 1'b0;
            cfg_cnt    <= '0;
            cfg_last   <= '0;
            col_cnt    <= '0;
            col_last   <= '0;
            right_last <= '0;
            blk_cnt    <= '0;
            blk_last   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= m_axis_tvalid && m_axis_tready && m_axis_tlast;
            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        is_1x1     <= cfg_is_1x1;
                        is_lrelu   <= cfg_is_lrelu;
                        is_max     <= cfg_is_max;
                        cfg_last   <= cfg_is_1x1 ? CFG_W'(CONFIG_BEATS_1X1_2 + 1)
                                                 : CFG_W'(CONFIG_BEATS_3X3_2 + 1);
                        col_last   <= (cfg_is_1x1 ? CNT_W'(cols_in) * CNT_W'(3)
                                                  : CNT_W'(cols_in)) - CNT_W'(1);
                        right_last <= CNT_W'(cols_in) - CNT_W'(1);
                        blk_last   <= blocks_in - BLOCKS_W'(1);
                        cfg_cnt    <= '0;
                        col_cnt    <= '0;
                        blk_cnt    <= '0;
                        state      <= CONFIG;
                    end
                end
                CONFIG: begin
                    if (s_hs) begin
                        if (cfg_cnt == cfg_last) begin
                            cfg_cnt <= '0;
                            state   <= DATA;
                        end else begin
                            cfg_cnt <= cfg_cnt + CFG_W'(1);
                        end
                    end
                end
                DATA: begin
                    if (s_hs) begin
                        if (last_beat) begin
                            state <= IDLE;
                        end else if (col_cnt == col_last) begin
                            col_cnt <= '0;
                            blk_cnt <= blk_cnt + BLOCKS_W'(1);
                        end else begin
                            col_cnt <= col_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    axis_reg_slice #(
        .WIDTH (SLICE_W)
    ) u_slice (
        .aclk      (aclk),
        .areset    (areset),
        .in_valid  (s_hs),
        .in_ready  (slice_ready),
        .in_data   ({last_beat, tuser, s_axis_tdata}),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready),
        .out_data  (slice_out)
    );

    assign {m_axis_tlast, m_axis_tuser, m_axis_tdata} = slice_out;

endmodule

// File: tb/tb_axis_lrelu_tuser_sequencer.sv
// Directed bench for axis_lrelu_tuser_sequencer: fixed frames, a stalled run,
// degenerate sizes and a mid-frame reset, checked against hand values and a beat model.
module tb_axis_lrelu_tuser_sequencer;
    import lrelu_pkg::*;

    localparam int TDW = 384;
    typedef logic [TDW+8:0] beat_t;  // {tlast, tuser[7:0], tdata}

    logic           aclk;
    logic           areset;
    logic           cfg_valid, cfg_ready, cfg_is_1x1, cfg_is_lrelu, cfg_is_max;
    logic [7:0]     cfg_cols, cfg_blocks;
    logic           s_tvalid, s_tready;
    logic [TDW-1:0] s_tdata;
    logic           m_tvalid, m_tready, m_tlast;
    logic [TDW-1:0] m_tdata;
    logic [7:0]     m_tuser;
    logic           frame_done;

    axis_lrelu_tuser_sequencer dut (
        .aclk          (aclk),
        .areset        (areset),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_is_1x1    (cfg_is_1x1),
        .cfg_is_lrelu  (cfg_is_lrelu),
        .cfg_is_max    (cfg_is_max),
        .cfg_cols      (cfg_cols),
        .cfg_blocks    (cfg_blocks),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tdata  (s_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tlast  (m_tlast),
        .m_axis_tuser  (m_tuser),
        .frame_done    (frame_done)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    fd_count = 0;
    beat_t exp_q[$];
    beat_t out_q[$];
    int    hs_cyc[$];
    beat_t cur;
    bit    rand_ready = 1'b0;
    logic  ready_fixed = 1'b1;

    assign cur = {m_tlast, m_tuser, m_tdata};

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [399:0] obs, input logic [399:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected {tlast, tuser} for accepted beat n of a frame (config beats first).
    function automatic logic [8:0] exp_tag(input bit f1x1, input bit fl, input bit fm,
                                           input int cols, input int blocks, input int n);
        int cfg_n = f1x1 ? 13 : 21;
        int c = (cols == 0) ? 1 : cols;
        int b = (blocks == 0) ? 1 : blocks;
        int k = f1x1 ? 3 : 1;
        int d, col, blk;
        logic [7:0] u;
        logic last;
        u = '0;
        last = 1'b0;
        u[I_IS_NOT_MAX] = !fm;
        u[I_IS_MAX]     = fm;
        u[I_IS_LRELU]   = fl;
        u[I_IS_1X1]     = f1x1;
        if (n >= cfg_n) begin
            d   = n - cfg_n;
            col = d % (k * c);
            blk = d / (k * c);
            u[I_IS_LEFT_COL]     = (col == 0);
            u[I_IS_RIGHT_COL]    = (col == c - 1);
            u[I_IS_TOP_BLOCK]    = (blk == 0);
            u[I_IS_BOTTOM_BLOCK] = (blk == b - 1) && (blk != 0);
            last = (d == k * c * b - 1);
        end
        return {last, u};
    endfunction

    // Output monitor: collects m beats, checks hold-under-stall and frame_done timing.
    logic  stalled = 1'b0;
    logic  prev_last_hs = 1'b0;
    beat_t held;
    always @(negedge aclk) begin
        if (areset) begin
            stalled      = 1'b0;
            prev_last_hs = 1'b0;
        end else begin
            if (frame_done || prev_last_hs) check("frame_done_timing", frame_done, prev_last_hs);
            if (frame_done) fd_count++;
            if (stalled) begin
                check("stall_valid", m_tvalid, 1'b1);
                check("stall_hold", cur, held);
            end
            if (s_tvalid && s_tready) hs_cyc.push_back(cyc);
            if (m_tvalid && m_tready) out_q.push_back(cur);
            prev_last_hs = m_tvalid && m_tready && m_tlast;
            stalled      = m_tvalid && !m_tready;
            held         = cur;
        end
    end

    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            m_tready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send_frame(input bit f1x1, input bit fl, input bit fm, input int cols,
                              input int blocks, input int fid, input bit gaps, input int data_limit);
        int cfg_n = f1x1 ? 13 : 21;
        int c = (cols == 0) ? 1 : cols;
        int b = (blocks == 0) ? 1 : blocks;
        int total = cfg_n + (f1x1 ? 3 : 1) * c * b;
        int limit = (data_limit < 0) ? total : cfg_n + data_limit;
        int budget;
        bit hs;
        cfg_valid = 1'b1;
        cfg_is_1x1 = f1x1;
        cfg_is_lrelu = fl;
        cfg_is_max = fm;
        cfg_cols = 8'(cols);
        cfg_blocks = 8'(blocks);
        budget = 0;
        do begin
            @(negedge aclk);
            hs = cfg_ready;
            budget++;
        end while (!hs && budget < 1000);
        tick();
        cfg_valid = 1'b0;
        if (!hs) begin
            check("cfg_timeout", 1'b0, 1'b1);
            return;
        end
        for (int n = 0; n < limit; n++) begin
            if (gaps) begin
                while ($urandom_range(0, 1) == 0) begin
                    s_tvalid = 1'b0;
                    tick();
                end
            end
            s_tvalid = 1'b1;
            s_tdata  = {12{16'(fid), 16'(n)}};
            budget = 0;
            do begin
                @(negedge aclk);
                hs = s_tready;
                budget++;
            end while (!hs && budget < 1000);
            if (!hs) begin
                check("s_timeout", 1'b0, 1'b1);
                s_tvalid = 1'b0;
                return;
            end
            exp_q.push_back({exp_tag(f1x1, fl, fm, cols, blocks, n), s_tdata});
            tick();
        end
        s_tvalid = 1'b0;
        if (data_limit < 0) check("cfg_ready_turnaround", cfg_ready, 1'b1);
    endtask

    task automatic drain_compare(input string tag);
        int budget = 0;
        while (out_q.size() < exp_q.size() && budget < 3000) begin
            tick();
            budget++;
        end
        repeat (3) tick();
        check({tag, "_count"}, out_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
            check($sformatf("%s_beat%0d", tag, i), out_q[i], exp_q[i]);
    endtask

    task automatic clear_q();
        exp_q.delete();
        out_q.delete();
        hs_cyc.delete();
    endtask

    initial begin
        areset = 1'b1;
        cfg_valid = 1'b0;
        cfg_is_1x1 = 1'b0;
        cfg_is_lrelu = 1'b0;
        cfg_is_max = 1'b0;
        cfg_cols = '0;
        cfg_blocks = '0;
        s_tvalid = 1'b0;
        s_tdata = '0;
        repeat (3) tick();
        @(negedge aclk);
        check("rst_m_tvalid", m_tvalid, 1'b0);
        check("rst_m_tlast", m_tlast, 1'b0);
        check("rst_m_tuser", m_tuser, 8'h00);
        check("rst_m_tdata", m_tdata, '0);
        check("rst_cfg_ready", cfg_ready, 1'b1);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_s_tready", s_tready, 1'b0);
        tick();
        areset = 1'b0;
        tick();

        // 3x3 then 1x1, back to back, no stalls.
        send_frame(1'b0, 1'b1, 1'b0, 3, 3, 1, 1'b0, -1);
        send_frame(1'b1, 1'b0, 1'b1, 3, 3, 2, 1'b0, -1);
        drain_compare("t12");
        check("t1_cfg_user", out_q[0][TDW+7 -: 8], 8'h05);
        check("t1_d0_user", out_q[21][TDW+7 -: 8], 8'h4D);
        check("t1_d7_last", out_q[28][TDW+8], 1'b0);
        check("t1_d8_user", out_q[29][TDW+7 -: 8], 8'h95);
        check("t1_d8_last", out_q[29][TDW+8], 1'b1);
        check("t2_cfg_user", out_q[30][TDW+7 -: 8], 8'h22);
        check("t2_d0_user", out_q[43][TDW+7 -: 8], 8'h6A);
        check("t2_d2_user", out_q[45][TDW+7 -: 8], 8'hAA);
        check("t2_d20_user", out_q[63][TDW+7 -: 8], 8'hB2);
        check("t2_d26_user", out_q[69][TDW+7 -: 8], 8'h32);
        check("t2_d26_last", out_q[69][TDW+8], 1'b1);
        check("t12_bubble", hs_cyc[30] - hs_cyc[29], 2);
        check("t12_frame_done", fd_count, 2);
        clear_q();

        // Random m_tready and s_tvalid over two back-to-back frames.
        rand_ready = 1'b1;
        send_frame(1'b0, 1'b1, 1'b0, 3, 3, 3, 1'b1, -1);
        send_frame(1'b1, 1'b0, 1'b1, 3, 3, 4, 1'b1, -1);
        drain_compare("t3");
        rand_ready = 1'b0;
        check("t3_frame_done", fd_count, 4);
        clear_q();

        // Single-beat frames: cols=blocks=1, and 0 which is treated as 1.
        send_frame(1'b0, 1'b1, 1'b0, 1, 1, 5, 1'b0, -1);
        send_frame(1'b0, 1'b1, 1'b0, 0, 0, 6, 1'b0, -1);
        drain_compare("t4");
        check("t4_user", out_q[21][TDW+7 -: 8], 8'hCD);
        check("t4_last", out_q[21][TDW+8], 1'b1);
        check("t4_zero_user", out_q[43][TDW+7 -: 8], 8'hCD);
        check("t4_zero_last", out_q[43][TDW+8], 1'b1);
        check("t4_frame_done", fd_count, 6);
        clear_q();

        // Reset while data beat 4 waits behind a stalled output.
        send_frame(1'b0, 1'b1, 1'b0, 3, 3, 7, 1'b0, 4);
        ready_fixed = 1'b0;
        repeat (2) tick();
        s_tvalid = 1'b1;
        s_tdata  = {12{16'd7, 16'd25}};
        repeat (2) tick();
        @(negedge aclk);
        check("t5_stalled_valid", m_tvalid, 1'b1);
        check("t5_stalled_s_tready", s_tready, 1'b0);
        tick();
        areset = 1'b1;
        tick();
        areset = 1'b0;
        s_tvalid = 1'b0;
        ready_fixed = 1'b1;
        @(negedge aclk);
        check("t5_post_rst_m_tvalid", m_tvalid, 1'b0);
        check("t5_post_rst_cfg_ready", cfg_ready, 1'b1);
        tick();
        clear_q();
        send_frame(1'b0, 1'b1, 1'b0, 3, 3, 8, 1'b0, -1);
        drain_compare("t5");
        check("t5_first_user", out_q[0][TDW+7 -: 8], 8'h05);
        check("t5_first_data", out_q[0][31:0], {16'd8, 16'd0});
        check("t5_frame_done", fd_count, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
